// File: rtl/result_pack_out.sv
// Output-side requantizer: adds per-layer bias to 16-lane accumulator beats, applies optional
// ReLU and a rounding right-shift to int8, and packs BEATS beats into one output FIFO word.
module result_pack_out #(
  parameter int unsigned BANDWIDTH = 512,
  parameter int unsigned BITWIDTH  = 32,
  parameter int unsigned LANES     = 16,
  parameter int unsigned OUT_BITS  = 8
) (
  input  logic                      clk_calc,
  input  logic                      rst_n,
  input  logic                      bias_vld,
  input  logic [BITWIDTH*LANES-1:0] bias_in,
  input  logic                      acc_vld,
  input  logic [BITWIDTH*LANES-1:0] acc_data,
  output logic                      acc_rdy,
  input  logic                      relu_en,
  input  logic [4:0]                shift,
  input  logic                      layer_finish,
  input  logic                      fifo_almost_full,
  output logic                      fifo_wr_en,
  output logic [BANDWIDTH-1:0]      fifo_wr_data,
  output logic                      layer_out_done
);

  localparam int unsigned BEATS  = BANDWIDTH / (LANES * OUT_BITS);
  localparam int unsigned BEAT_W = LANES * OUT_BITS;
  localparam int unsigned DATA_W = BITWIDTH * LANES;
  localparam int unsigned SUM_W  = BITWIDTH + 2;
  localparam int unsigned RQ_W   = BITWIDTH + 3;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic signed [RQ_W-1:0] SAT_MAX = RQ_W'((2 ** (OUT_BITS - 1)) - 1);
  localparam logic signed [RQ_W-1:0] SAT_MIN = RQ_W'(-(2 ** (OUT_BITS - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              bias_held_q, bias_held_d;
  logic              rebias_q, rebias_d;
  logic [DATA_W-1:0] bias_q;

  logic                    s1_vld_q;
  logic [LANES*SUM_W-1:0]  s1_sum_q, s1_sum_d;
  logic                    s2_vld_q;
  logic [BEAT_W-1:0]       s2_q, s2_d;

  logic [BANDWIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [BANDWIDTH-1:0] wr_data_q, wr_data_d;
  logic                 done_q, done_d;

  logic flush_wr;
  logic clr_cnt;
  logic beat_acc;

  logic signed [SUM_W-1:0] lane_sum;
  logic signed [RQ_W-1:0]  lane_v, lane_rnd, lane_r;

  assign beat_acc       = acc_vld & acc_rdy;
  assign fifo_wr_en     = wr_en_q;
  assign fifo_wr_data   = wr_data_q;
  assign layer_out_done = done_q;

  // Layer control: bias bookkeeping, input handshake and flush sequencing
  always_comb begin
    state_d     = state_q;
    bias_held_d = bias_held_q;
    rebias_d    = rebias_q;
    acc_rdy     = 1'b0;
    flush_wr    = 1'b0;
    clr_cnt     = 1'b0;
    done_d      = 1'b0;
    if (bias_vld) begin
      bias_held_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (bias_held_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        acc_rdy = ~fifo_almost_full;
        if (layer_finish) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (bias_vld) begin
          rebias_d = 1'b1;
        end
        // Partial word goes out first; DONE follows once the counter reads zero
        if (!s1_vld_q && !s2_vld_q) begin
          if (cnt_q != '0) begin
            flush_wr = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        bias_held_d = bias_vld | rebias_q;
        rebias_d    = 1'b0;
        clr_cnt     = 1'b1;
        state_d     = (bias_vld | rebias_q) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // S1: widen and add the bias held at acceptance time
  always_comb begin
    s1_sum_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      s1_sum_d[i*SUM_W +: SUM_W] = SUM_W'($signed(acc_data[i*BITWIDTH +: BITWIDTH]))
                                 + SUM_W'($signed(bias_q[i*BITWIDTH +: BITWIDTH]));
    end
  end

  // S2: ReLU, round-half-up arithmetic shift, saturate to signed OUT_BITS
  always_comb begin
    s2_d     = '0;
    lane_sum = '0;
    lane_v   = '0;
    lane_rnd = '0;
    lane_r   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_sum = $signed(s1_sum_q[i*SUM_W +: SUM_W]);
      if (relu_en && lane_sum[SUM_W-1]) begin
        lane_v = '0;
      end else begin
        lane_v = RQ_W'(lane_sum);
      end
      if (shift != 5'd0) begin
        lane_rnd = RQ_W'(1) << (shift - 5'd1);
      end else begin
        lane_rnd = '0;
      end
      lane_r = (lane_v + lane_rnd) >>> shift;
      if (lane_r > SAT_MAX) begin
        s2_d[i*OUT_BITS +: OUT_BITS] = OUT_BITS'(SAT_MAX);
      end else if (lane_r < SAT_MIN) begin
        s2_d[i*OUT_BITS +: OUT_BITS] = OUT_BITS'(SAT_MIN);
      end else begin
        s2_d[i*OUT_BITS +: OUT_BITS] = OUT_BITS'(lane_r);
      end
    end
  end

  // S3: place beats into the word; emit on the last beat or on a layer flush
  always_comb begin
    word_d    = word_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    if (s2_vld_q) begin
      for (int k = 0; k < int'(BEATS); k++) begin
        if (cnt_q == CNT_W'(k)) begin
          word_d[k*BEAT_W +: BEAT_W] = s2_q;
        end
      end
      if (cnt_q == CNT_W'(BEATS - 1)) begin
        wr_en_d   = 1'b1;
        wr_data_d = word_d;
        word_d    = '0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (flush_wr) begin
      wr_en_d   = 1'b1;
      wr_data_d = word_q;
      word_d    = '0;
      cnt_d     = '0;
    end else if (clr_cnt) begin
      word_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bias_held_q <= 1'b0;
      rebias_q    <= 1'b0;
      bias_q      <= '0;
    end else begin
      state_q     <= state_d;
      bias_held_q <= bias_held_d;
      rebias_q    <= rebias_d;
      if (bias_vld) begin
        bias_q <= bias_in;
      end
    end
  end

  always_ff @(posedge clk_calc or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sum_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_q      <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      s1_vld_q  <= beat_acc;
      s1_sum_q  <= s1_sum_d;
      s2_vld_q  <= s1_vld_q;
      s2_q      <= s2_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_result_pack_out.sv
// Scoreboard bench for result_pack_out: an arithmetic reference model predicts each FIFO word
// and layer-done pulse; a monitor compares them as the DUT emits them.
module tb_result_pack_out;

  logic         clk_calc;
  logic         rst_n;
  logic         bias_vld;
  logic [511:0] bias_in;
  logic         acc_vld;
  logic [511:0] acc_data;
  logic         acc_rdy;
  logic         relu_en;
  logic [4:0]   shift;
  logic         layer_finish;
  logic         fifo_almost_full;
  logic         fifo_wr_en;
  logic [511:0] fifo_wr_data;
  logic         layer_out_done;

  result_pack_out dut (
    .clk_calc        (clk_calc),
    .rst_n           (rst_n),
    .bias_vld        (bias_vld),
    .bias_in         (bias_in),
    .acc_vld         (acc_vld),
    .acc_data        (acc_data),
    .acc_rdy         (acc_rdy),
    .relu_en         (relu_en),
    .shift           (shift),
    .layer_finish    (layer_finish),
    .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
    .layer_out_done  (layer_out_done)
  );

  initial clk_calc = 1'b0;
  always #5 clk_calc = ~clk_calc;

  int cyc = 0;
  always @(posedge clk_calc) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] exp_q[$];
  logic [127:0] part_q[$];
  int           exp_done   = 0;
  logic [511:0] mbias      = '0;
  bit           layer_open = 1'b0;

  int           n_wr = 0, n_done = 0;
  int           last_wr_cyc = -100, last_done_cyc = -100, last_acc_cyc = -100;
  logic [511:0] last_wr_data = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, ReLU, floor((v + p/2) / p) with p = 2^shift, clamp to int8
  function automatic logic [127:0] model_beat(input logic [511:0] acc, input logic [511:0] b,
                                              input bit relu, input int sh);
    logic [127:0] r;
    longint v, p, q;
    r = '0;
    p = longint'(1) << sh;
    for (int i = 0; i < 16; i++) begin
      v = longint'($signed(acc[i*32 +: 32])) + longint'($signed(b[i*32 +: 32]));
      if (relu && v < 0) v = 0;
      q = v + p / 2;
      q = (q >= 0) ? q / p : -((-q + p - 1) / p);
      if (q > 127) q = 127;
      else if (q < -128) q = -128;
      r[i*8 +: 8] = 8'(q);
    end
    return r;
  endfunction

  function automatic logic [511:0] fill(input int val);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(val);
    return v;
  endfunction

  function automatic logic [511:0] rnd_vec();
    logic [511:0] v;
    int x;
    for (int i = 0; i < 16; i++) begin
      x = int'($urandom());
      x = x >>> $urandom_range(12, 31);
      v[i*32 +: 32] = 32'(x);
    end
    return v;
  endfunction

  task automatic push_word();
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < part_q.size(); k++) w[k*128 +: 128] = part_q[k];
    exp_q.push_back(w);
    part_q.delete();
  endtask

  // One clock of stimulus; the model advances on what the handshake shows was accepted
  task automatic step(input bit bv, input logic [511:0] bias, input bit av, input logic [511:0] acc,
                      input bit lf, input bit af, output bit taken);
    @(negedge clk_calc);
    bias_vld = bv; bias_in = bias; acc_vld = av; acc_data = acc;
    layer_finish = lf; fifo_almost_full = af;
    #1;
    taken = av && acc_rdy;
    if (af) check("rdy_low_when_almost_full", 512'(acc_rdy), 512'(0));
    if (taken) begin
      part_q.push_back(model_beat(acc, mbias, relu_en, int'(shift)));
      last_acc_cyc = cyc;
      if (part_q.size() == 4) push_word();
    end
    if (bv) begin
      mbias = bias;
      layer_open = 1'b1;
    end
    if (lf && layer_open) begin
      if (part_q.size() != 0) push_word();
      exp_done++;
      layer_open = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, t);
  endtask

  task automatic start_layer(input logic [511:0] b, input bit relu, input logic [4:0] sh);
    bit t;
    relu_en = relu;
    shift = sh;
    step(1, b, 0, '0, 0, 0, t);
    idle(3);
  endtask

  task automatic send(input logic [511:0] acc);
    bit t;
    int n;
    t = 0; n = 0;
    while (!t && n < 50) begin
      step(0, '0, 1, acc, 0, 0, t);
      n++;
    end
    check("beat_accepted", 512'(t), 512'(1));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 60) begin
      idle(1);
      n++;
    end
    check("layer_done_seen", 512'(n_done), 512'(target));
  endtask

  task automatic end_layer(output int lf_cyc);
    int tgt;
    bit t;
    tgt = n_done + 1;
    step(0, '0, 0, '0, 1, 0, t);
    lf_cyc = cyc;
    wait_done(tgt);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, 512'(fifo_wr_en), 512'(0));
    check({tag, "_wr_data"}, fifo_wr_data, 512'(0));
    check({tag, "_done"}, 512'(layer_out_done), 512'(0));
    check({tag, "_acc_rdy"}, 512'(acc_rdy), 512'(0));
  endtask

  task automatic do_reset();
    @(negedge clk_calc);
    rst_n = 1'b0;
    bias_vld = 0; acc_vld = 0; layer_finish = 0; fifo_almost_full = 0;
    part_q.delete();
    exp_q.delete();
    exp_done = 0;
    layer_open = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk_calc);
    rst_n = 1'b1;
  endtask

  // Monitor: every write and done pulse is matched against the scoreboard
  always @(negedge clk_calc) begin
    if (rst_n) begin
      if (fifo_wr_en) begin
        n_wr++;
        last_wr_cyc = cyc;
        last_wr_data = fifo_wr_data;
        if (exp_q.size() == 0) check("unexpected_write", 512'(fifo_wr_en), 512'(0));
        else check("wr_data", fifo_wr_data, exp_q.pop_front());
      end
      if (layer_out_done) begin
        n_done++;
        last_done_cyc = cyc;
        if (exp_done == 0) check("unexpected_done", 512'(layer_out_done), 512'(0));
        else begin
          exp_done--;
          check("done_words_pending", 512'(exp_q.size()), 512'(0));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lf_cyc, w0, d0, nb, got, guard, af_left;
    bit t, af;
    logic [511:0] expw;

    rst_n = 1'b0;
    bias_vld = 0; bias_in = '0; acc_vld = 0; acc_data = '0;
    relu_en = 0; shift = '0; layer_finish = 0; fifo_almost_full = 0;
    repeat (3) @(negedge clk_calc);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Basic word: (100 + 10 + 2) >> 2 = 28
    start_layer(fill(10), 0, 5'd2);
    for (int k = 0; k < 4; k++) send(fill(100));
    end_layer(lf_cyc);
    check("latency_4th_beat", 512'(last_wr_cyc - last_acc_cyc), 512'(3));
    expw = {64{8'h1C}};
    check("word_0x1c", last_wr_data, expw);

    // Saturation and ReLU corners
    start_layer(fill(-1000), 1, 5'd0);
    for (int k = 0; k < 4; k++) send(fill(0));
    end_layer(lf_cyc);
    expw = {64{8'h00}};
    check("relu_clamp_zero", last_wr_data, expw);
    start_layer(fill(-1000), 0, 5'd0);
    for (int k = 0; k < 4; k++) send(fill(0));
    end_layer(lf_cyc);
    expw = {64{8'h80}};
    check("sat_neg", last_wr_data, expw);
    start_layer(fill(0), 0, 5'd0);
    for (int k = 0; k < 4; k++) send(fill(1000));
    end_layer(lf_cyc);
    expw = {64{8'h7F}};
    check("sat_pos", last_wr_data, expw);

    // Six beats, the last one accepted together with layer_finish
    w0 = n_wr;
    start_layer(fill(0), 0, 5'd0);
    for (int k = 0; k < 5; k++) send(fill(k));
    step(0, '0, 1, fill(5), 1, 0, t);
    check("beat_with_finish_taken", 512'(t), 512'(1));
    wait_done(n_done + 1);
    check("partial_writes", 512'(n_wr - w0), 512'(2));
    expw = '0;
    for (int i = 0; i < 16; i++) begin
      expw[i*8 +: 8] = 8'd4;
      expw[128 + i*8 +: 8] = 8'd5;
    end
    check("partial_word", last_wr_data, expw);
    check("done_after_partial", 512'(last_done_cyc - last_wr_cyc), 512'(1));

    // Back-pressure window of 10 cycles mid-stream
    w0 = n_wr;
    start_layer(fill(-7), 0, 5'd1);
    got = 0;
    for (int c = 0; c < 40 && got < 12; c++) begin
      af = (c >= 3 && c < 13);
      step(0, '0, 1, fill(c * 3 - 20), 0, af, t);
      if (t) got++;
    end
    check("af_beats_all_sent", 512'(got), 512'(12));
    end_layer(lf_cyc);
    check("af_write_count", 512'(n_wr - w0), 512'(3));

    // Empty layer: no write, done two cycles after finish, then stalled until re-bias
    w0 = n_wr;
    start_layer(fill(0), 0, 5'd0);
    end_layer(lf_cyc);
    check("empty_no_write", 512'(n_wr - w0), 512'(0));
    check("empty_done_delay", 512'(last_done_cyc - lf_cyc), 512'(2));
    for (int k = 0; k < 3; k++) begin
      step(0, '0, 1, fill(1), 0, 0, t);
      check("idle_rdy_low", 512'(t), 512'(0));
    end

    // layer_finish while idle is ignored
    d0 = n_done;
    step(0, '0, 0, '0, 1, 0, t);
    idle(5);
    check("finish_in_idle_ignored", 512'(n_done - d0), 512'(0));

    // Reset with two beats of a word in flight
    start_layer(fill(9), 0, 5'd0);
    send(fill(1));
    send(fill(2));
    do_reset();
    w0 = n_wr;
    idle(6);
    check("no_write_after_reset", 512'(n_wr - w0), 512'(0));
    start_layer(fill(5), 0, 5'd0);
    for (int k = 0; k < 4; k++) send(fill(3));
    end_layer(lf_cyc);
    check("post_reset_one_word", 512'(n_wr - w0), 512'(1));
    expw = {64{8'h08}};
    check("post_reset_word", last_wr_data, expw);

    // Randomized layers with gaps, back-pressure bursts and occasional mid-layer bias
    af_left = 0;
    for (int l = 0; l < 10; l++) begin
      start_layer(rnd_vec(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 12)));
      nb = $urandom_range(1, 13);
      got = 0;
      guard = 0;
      while (got < nb && guard < 400) begin
        if (af_left == 0 && $urandom_range(0, 15) == 0) af_left = $urandom_range(1, 6);
        af = (af_left > 0);
        if (af_left > 0) af_left--;
        step(($urandom_range(0, 19) == 0), rnd_vec(), ($urandom_range(0, 3) != 0), rnd_vec(),
             0, af, t);
        if (t) got++;
        guard++;
      end
      check("rand_beats_sent", 512'(got), 512'(nb));
      end_layer(lf_cyc);
    end

    idle(5);
    check("scoreboard_words_drained", 512'(exp_q.size()), 512'(0));
    check("scoreboard_done_drained", 512'(exp_done), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
